// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: reconfiguration request channel of clk_div_gen.
//
// Handshake: a request (CFG_CH, CFG_DIV) is transferred on a rising edge
// where CFG_VALID=1 and CFG_READY=1. While CFG_READY=0 the requester keeps
// CFG_VALID high and CFG_CH/CFG_DIV stable; nothing is lost or consumed.
//
// Signals:
//   CFG_VALID  requester -> block  request present
//   CFG_READY  block -> requester  request can be accepted this cycle
//   CFG_CH     requester -> block  target channel index
//   CFG_DIV    requester -> block  new divide ratio
interface clk_div_gen_if #(
    parameter int DIV_W = 16
);
    logic             CFG_VALID;
    logic             CFG_READY;
    logic [2:0]       CFG_CH;
    logic [DIV_W-1:0] CFG_DIV;

    modport master (
        output CFG_VALID,
        output CFG_CH,
        output CFG_DIV,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID,
        input  CFG_CH,
        input  CFG_DIV,
        output CFG_READY
    );
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel integer clock-enable / divided-clock generator
// with a lock FSM. Each channel divides CLK_IN by its own ratio D (>=2).
// A reconfiguration writes a shadow divisor and forces a settle period of
// LOCK_CYCLES cycles with all outputs low; on re-entering RUN every shadow
// divisor becomes active and all channels restart phase-aligned.
//
// Ports:
//   CLK_IN       single clock, rising edge
//   RESET_N      synchronous active-low reset
//   cfg          reconfiguration request channel (slave side)
//   CLK_OUT      registered divided clock per channel
//   CLK_EN       registered one-cycle pulse on each CLK_OUT rising phase
//   LOCKED       outputs valid and stable (FSM in RUN)
//   dbg_state_o  lock FSM state (0 = SETTLE, 1 = RUN)
module clk_div_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 64
) (
    input  logic              CLK_IN,
    input  logic              RESET_N,
    clk_div_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] CLK_OUT,
    output logic [NUM_CH-1:0] CLK_EN,
    output logic              LOCKED,
    output logic              dbg_state_o
);

    localparam int SW = $clog2(LOCK_CYCLES + 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(LOCK_CYCLES - 1);
    // Ratios below 2 cannot produce a toggling output, so they are floored.
    localparam logic [DIV_W-1:0] DEF_DIV = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     settle_q;
    logic [DIV_W-1:0]  shadow_q [NUM_CH];
    logic [DIV_W-1:0]  div_q    [NUM_CH];
    logic [DIV_W-1:0]  cnt_q    [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q;
    logic [NUM_CH-1:0] clk_en_q;

    // Next values of the channel datapath when staying in RUN.
    logic [DIV_W-1:0]  cnt_d    [NUM_CH];
    logic [DIV_W:0]    half_w   [NUM_CH];
    logic [NUM_CH-1:0] clk_out_d;
    logic [NUM_CH-1:0] clk_en_d;

    logic             accept;
    logic             ch_ok;
    logic [DIV_W-1:0] div_wr;

    assign accept = cfg.CFG_VALID && cfg.CFG_READY;
    assign ch_ok  = ({29'd0, cfg.CFG_CH} < 32'(NUM_CH));
    assign div_wr = (cfg.CFG_DIV < DIV_W'(2)) ? DIV_W'(2) : cfg.CFG_DIV;

    always_comb begin
        cnt_d     = '{default: '0};
        half_w    = '{default: '0};
        clk_out_d = '0;
        clk_en_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Compare against D-1 so a divisor of 2^DIV_W-1 wraps without
            // the counter ever needing an extra bit.
            cnt_d[i]     = (cnt_q[i] == div_q[i] - 1'b1) ? '0 : cnt_q[i] + 1'b1;
            // (D+1)/2 computed one bit wider so D = 2^DIV_W-1 does not overflow.
            half_w[i]    = ({1'b0, div_q[i]} + 1'b1) >> 1;
            clk_out_d[i] = ({1'b0, cnt_d[i]} < half_w[i]);
            clk_en_d[i]  = (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            state_q   <= SETTLE;
            settle_q  <= '0;
            shadow_q  <= '{default: DEF_DIV};
            div_q     <= '{default: DEF_DIV};
            cnt_q     <= '{default: '0};
            clk_out_q <= '0;
            clk_en_q  <= '0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        // First RUN cycle: counters at 0, so every channel
                        // starts high with an enable pulse, phase-aligned.
                        state_q   <= RUN;
                        settle_q  <= '0;
                        div_q     <= shadow_q;
                        cnt_q     <= '{default: '0};
                        clk_out_q <= '1;
                        clk_en_q  <= '1;
                    end else begin
                        settle_q  <= settle_q + 1'b1;
                        cnt_q     <= '{default: '0};
                        clk_out_q <= '0;
                        clk_en_q  <= '0;
                    end
                end
                RUN: begin
                    if (accept && ch_ok) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (cfg.CFG_CH == 3'(i)) begin
                                shadow_q[i] <= div_wr;
                            end
                        end
                        state_q   <= SETTLE;
                        settle_q  <= '0;
                        cnt_q     <= '{default: '0};
                        clk_out_q <= '0;
                        clk_en_q  <= '0;
                    end else begin
                        // Out-of-range requests are consumed here with no effect.
                        cnt_q     <= cnt_d;
                        clk_out_q <= clk_out_d;
                        clk_en_q  <= clk_en_d;
                    end
                end
                default: begin
                    state_q <= SETTLE;
                end
            endcase
        end
    end

    assign LOCKED        = (state_q == RUN);
    assign cfg.CFG_READY = LOCKED;
    assign CLK_OUT       = clk_out_q;
    assign CLK_EN        = clk_en_q;
    assign dbg_state_o   = (state_q == RUN);

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed scenarios plus randomized reconfiguration traffic
// for clk_div_gen, checked cycle by cycle against a behavioural model that
// tracks "time since RUN entry" and derives each channel's phase as t mod D.
module tb_clk_div_gen;
    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 2;
    localparam int LOCK_CYCLES = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] clk_en;
    logic              locked;
    logic              dbg_state;

    clk_div_gen_if #(.DIV_W(DIV_W)) cfg_if ();

    clk_div_gen #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .CLK_IN     (clk),
        .RESET_N    (rst_n),
        .cfg        (cfg_if),
        .CLK_OUT    (clk_out),
        .CLK_EN     (clk_en),
        .LOCKED     (locked),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    bit m_run;
    int m_left;
    int m_t;
    int m_shadow [NUM_CH];
    int m_active [NUM_CH];
    bit m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies the inputs the DUT sampled on this rising edge.
    task automatic model_step();
        int ch;
        int dv;
        m_acc = 1'b0;
        ch = int'(cfg_if.CFG_CH);
        dv = int'(cfg_if.CFG_DIV);
        if (!rst_n) begin
            m_run  = 1'b0;
            m_left = LOCK_CYCLES;
            m_t    = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_shadow[i] = DEFAULT_DIV;
                m_active[i] = DEFAULT_DIV;
            end
        end else if (!m_run) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 1'b1;
                m_t   = 0;
                for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
            end
        end else if (cfg_if.CFG_VALID) begin
            m_acc = 1'b1;
            if (ch < NUM_CH) begin
                m_shadow[ch] = (dv < 2) ? 2 : dv;
                m_run  = 1'b0;
                m_left = LOCK_CYCLES;
            end else begin
                m_t++;
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] e_out;
        logic [NUM_CH-1:0] e_en;
        int ph;
        for (int i = 0; i < NUM_CH; i++) begin
            ph = m_t % m_active[i];
            e_out[i] = m_run && (ph < (m_active[i] + 1) / 2);
            e_en[i]  = m_run && (ph == 0);
        end
        chk("LOCKED",    32'(locked),        32'(m_run));
        chk("CFG_READY", 32'(cfg_if.CFG_READY), 32'(m_run));
        chk("DBG_STATE", 32'(dbg_state),     32'(m_run));
        chk("CLK_OUT",   32'(clk_out),       32'(e_out));
        chk("CLK_EN",    32'(clk_en),        32'(e_en));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Holds the request until the model sees it accepted (bounded).
    task automatic send(input int ch, input int div);
        int waited;
        cfg_if.CFG_VALID = 1'b1;
        cfg_if.CFG_CH    = 3'(ch);
        cfg_if.CFG_DIV   = DIV_W'(div);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!m_acc && waited < 200);
        cfg_if.CFG_VALID = 1'b0;
    endtask

    // Counts LOCKED-low cycles from the current cycle onwards.
    task automatic measure_lock(input string tag);
        int lz;
        lz = 0;
        for (int k = 0; k < 50 && locked !== 1'b1; k++) begin
            lz++;
            tick();
        end
        chk(tag, 32'(lz), 32'(LOCK_CYCLES));
    endtask

    // Records 10 cycles of one channel starting at the current cycle.
    task automatic record(input int ch, output logic [9:0] out_seq, output logic [9:0] en_seq);
        for (int k = 0; k < 10; k++) begin
            out_seq[k] = clk_out[ch];
            en_seq[k]  = clk_en[ch];
            tick();
        end
    endtask

    logic [9:0] s_out0, s_en0, s_out1, s_en1;

    initial begin
        cfg_if.CFG_VALID = 1'b0;
        cfg_if.CFG_CH    = '0;
        cfg_if.CFG_DIV   = '0;
        rst_n = 1'b0;
        @(negedge clk);

        // Power-up: reset for 3 cycles, then lock and run /2 on both channels.
        repeat (3) tick();
        rst_n = 1'b1;
        measure_lock("POWERUP_LOCK");
        record(0, s_out0, s_en0);
        chk("PU_OUT0", 32'(s_out0), 32'(10'b0101010101));
        chk("PU_EN0",  32'(s_en0),  32'(10'b0101010101));

        // Reconfigure channel 1 to /5.
        send(1, 5);
        measure_lock("RECFG_LOCK");
        begin
            for (int k = 0; k < 10; k++) begin
                s_out0[k] = clk_out[0];
                s_out1[k] = clk_out[1];
                s_en1[k]  = clk_en[1];
                tick();
            end
        end
        chk("DIV5_OUT1", 32'(s_out1), 32'(10'b0011100111));
        chk("DIV5_EN1",  32'(s_en1),  32'(10'b0000100001));
        chk("DIV5_OUT0", 32'(s_out0), 32'(10'b0101010101));

        // Divide floor: 0 and 1 both behave as /2.
        send(0, 0);
        measure_lock("FLOOR0_LOCK");
        record(0, s_out0, s_en0);
        chk("FLOOR0_OUT0", 32'(s_out0), 32'(10'b0101010101));
        send(0, 1);
        measure_lock("FLOOR1_LOCK");
        record(0, s_out0, s_en0);
        chk("FLOOR1_OUT0", 32'(s_out0), 32'(10'b0101010101));

        // Out-of-range channel: consumed, lock kept.
        send(3, 7);
        chk("OOR_LOCKED", 32'(locked), 32'(1));
        repeat (10) tick();

        // Back-pressure: second request stalls through SETTLE.
        send(1, 3);
        send(0, 4);
        chk("BP_UNLOCK", 32'(locked), 32'(0));
        measure_lock("BP_LOCK");
        record(0, s_out0, s_en0);
        chk("BP_OUT0", 32'(s_out0), 32'(10'b0011001100 ^ 10'b1111111111));
        repeat (6) tick();

        // Reset during the 4th settle cycle after a /5 request.
        send(1, 5);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("MIDRST_OUT", 32'(clk_out), 32'(0));
        rst_n = 1'b1;
        measure_lock("MIDRST_LOCK");
        record(1, s_out1, s_en1);
        chk("MIDRST_OUT1", 32'(s_out1), 32'(10'b0101010101));

        // Maximum divisor: long high phase from RUN entry.
        send(0, 16'hFFFF);
        measure_lock("MAX_LOCK");
        repeat (40) tick();

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rst_n = 1'b1;
            end
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
            repeat ($urandom_range(0, 30)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
